reaction_timer_np: RTL and testbench

//  N-player successor to the single-player reaction timer core. Arms on a start pulse, waits a

---
 rtl/reaction_timer_np.sv | 203 ++++++++++++++++++++
 tb/tb_reaction_timer_np.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/reaction_timer_np.sv
// N-player reaction timer: random arm delay, per-player ms timing, foul/winner resolution.
// Optional best-time tracking is built only when BEST_TIME_EN is defined; otherwise oBEST_TIME is all-ones.
module reaction_timer_np #(
  parameter int          N_PLAYERS    = 2,
  parameter int          CNT_W        = 16,
  parameter int          CLK_HZ       = 50_000_000,
  parameter int          SIM_MODE     = 0,
  parameter int          MIN_DELAY_MS = 1000,
  parameter logic [11:0] DELAY_MASK   = 12'hFFF,
  parameter int          TIMEOUT_MS   = 5000
) (
  input  logic                         CLK_50,
  input  logic                         RESET_N,
  input  logic                         iSTART,
  input  logic [N_PLAYERS-1:0]         iKEY_N,
  output logic                         oGO_LED,
  output logic [1:0]                   oSTATE,
  output logic [N_PLAYERS*CNT_W-1:0]   oTIME,
  output logic [N_PLAYERS-1:0]         oDONE_MASK,
  output logic [N_PLAYERS-1:0]         oFOUL_MASK,
  output logic [2:0]                   oWINNER,
  output logic                         oWIN_VALID,
  output logic                         oROUND_DONE,
  output logic [CNT_W-1:0]             oBEST_TIME
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_TIMING = 2'd2;
  localparam logic [1:0] S_RESULT = 2'd3;

  localparam int TICK_CLKS = (SIM_MODE != 0) ? 50 : CLK_HZ / 1000;
  localparam int DIV_W     = $clog2(TICK_CLKS + 1);

  localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(TICK_CLKS - 1);
  localparam logic [CNT_W-1:0]     CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]     TMO_LAST = CNT_W'(TIMEOUT_MS - 1);
  localparam logic [N_PLAYERS-1:0] ALL_SET  = '1;

  logic [1:0]                 state_q, state_d;
  logic [15:0]                lfsr_q;
  logic [DIV_W-1:0]           div_q, div_d;
  logic [31:0]                delay_q, delay_d;
  logic [CNT_W-1:0]           tmo_q, tmo_d;
  logic [N_PLAYERS*CNT_W-1:0] time_q, time_d;
  logic [N_PLAYERS-1:0]       done_q, done_d;
  logic [N_PLAYERS-1:0]       foul_q, foul_d;
  logic [2:0]                 winner_q, winner_d;
  logic                       win_vld_q, win_vld_d;
  logic                       round_done_q;
  logic [N_PLAYERS-1:0]       key_s1_q, key_s2_q, key_prev_q;
  logic [N_PLAYERS-1:0]       key_fall, elig;
  logic                       tick, enter_result;

  assign key_fall     = key_prev_q & ~key_s2_q;
  assign tick         = (div_q == DIV_LAST);
  assign enter_result = (state_d == S_RESULT) && (state_q != S_RESULT);

  always_comb begin
    div_d = (tick || (state_d != state_q)) ? '0 : div_q + 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    delay_d   = delay_q;
    tmo_d     = tmo_q;
    time_d    = time_q;
    done_d    = done_q;
    foul_d    = foul_q;
    winner_d  = winner_q;
    win_vld_d = win_vld_q;
    elig      = '0;
    case (state_q)
      S_IDLE, S_RESULT: begin
        if (iSTART) begin
          time_d    = '0;
          done_d    = '0;
          foul_d    = '0;
          winner_d  = '0;
          win_vld_d = 1'b0;
          tmo_d     = '0;
          delay_d   = 32'(MIN_DELAY_MS) + {20'd0, lfsr_q[11:0] & DELAY_MASK};
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        for (int i = 0; i < N_PLAYERS; i++) begin
          if (key_fall[i] && !foul_q[i]) begin
            foul_d[i]                 = 1'b1;
            time_d[i*CNT_W +: CNT_W]  = CNT_MAX;
          end
        end
        if (foul_d == ALL_SET) begin
          state_d = S_RESULT;
        end else if (delay_q == 32'd0) begin
          state_d = S_TIMING;
        end else if (tick) begin
          delay_d = delay_q - 32'd1;
          if (delay_q == 32'd1) state_d = S_TIMING;
        end
      end
      S_TIMING: begin
        elig = key_fall & ~done_q & ~foul_q;
        // A press in a tick cycle freezes the pre-increment count.
        for (int i = 0; i < N_PLAYERS; i++) begin
          if (elig[i]) begin
            done_d[i] = 1'b1;
          end else if (tick && !done_q[i] && !foul_q[i] &&
                       time_q[i*CNT_W +: CNT_W] != CNT_MAX) begin
            time_d[i*CNT_W +: CNT_W] = time_q[i*CNT_W +: CNT_W] + 1'b1;
          end
        end
        if (!win_vld_q) begin
          for (int i = N_PLAYERS - 1; i >= 0; i--) begin
            if (elig[i]) begin
              winner_d  = 3'(i);
              win_vld_d = 1'b1;
            end
          end
        end
        if ((done_d | foul_q) == ALL_SET) begin
          state_d = S_RESULT;
        end else if (tick) begin
          if (tmo_q == TMO_LAST) begin
            state_d = S_RESULT;
            for (int i = 0; i < N_PLAYERS; i++) begin
              if (!done_d[i] && !foul_q[i]) time_d[i*CNT_W +: CNT_W] = CNT_MAX;
            end
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= S_IDLE;
      lfsr_q       <= 16'hACE1;
      div_q        <= '0;
      delay_q      <= '0;
      tmo_q        <= '0;
      time_q       <= '0;
      done_q       <= '0;
      foul_q       <= '0;
      winner_q     <= '0;
      win_vld_q    <= 1'b0;
      round_done_q <= 1'b0;
      key_s1_q     <= '1;
      key_s2_q     <= '1;
      key_prev_q   <= '1;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      div_q        <= div_d;
      delay_q      <= delay_d;
      tmo_q        <= tmo_d;
      time_q       <= time_d;
      done_q       <= done_d;
      foul_q       <= foul_d;
      winner_q     <= winner_d;
      win_vld_q    <= win_vld_d;
      round_done_q <= enter_result;
      key_s1_q     <= iKEY_N;
      key_s2_q     <= key_s1_q;
      key_prev_q   <= key_s2_q;
    end
  end

`ifdef BEST_TIME_EN
  logic [CNT_W-1:0] best_q, best_d, win_time;

  always_comb begin
    win_time = CNT_MAX;
    for (int i = 0; i < N_PLAYERS; i++) begin
      if (winner_d == 3'(i)) win_time = time_d[i*CNT_W +: CNT_W];
    end
    best_d = best_q;
    if (enter_result && win_vld_d && (win_time < best_q)) best_d = win_time;
  end

  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) best_q <= CNT_MAX;
    else          best_q <= best_d;
  end

  assign oBEST_TIME = best_q;
`else
  assign oBEST_TIME = CNT_MAX;
`endif

  assign oGO_LED     = (state_q == S_TIMING);
  assign oSTATE      = state_q;
  assign oTIME       = time_q;
  assign oDONE_MASK  = done_q;
  assign oFOUL_MASK  = foul_q;
  assign oWINNER     = winner_q;
  assign oWIN_VALID  = win_vld_q;
  assign oROUND_DONE = round_done_q;

endmodule

// File: tb/tb_reaction_timer_np.sv
// Scoreboard bench for reaction_timer_np (fast tick, 2 players, 10 ms delay, 400 ms timeout).
module tb_reaction_timer_np;

  logic        CLK_50  = 1'b0;
  logic        RESET_N = 1'b0;
  logic        iSTART  = 1'b0;
  logic [1:0]  iKEY_N  = 2'b11;
  logic        oGO_LED;
  logic [1:0]  oSTATE;
  logic [31:0] oTIME;
  logic [1:0]  oDONE_MASK, oFOUL_MASK;
  logic [2:0]  oWINNER;
  logic        oWIN_VALID, oROUND_DONE;
  logic [15:0] oBEST_TIME;

  reaction_timer_np #(
    .N_PLAYERS(2), .CNT_W(16), .CLK_HZ(50_000_000), .SIM_MODE(1),
    .MIN_DELAY_MS(10), .DELAY_MASK(12'h000), .TIMEOUT_MS(400)
  ) dut (
    .CLK_50(CLK_50), .RESET_N(RESET_N), .iSTART(iSTART), .iKEY_N(iKEY_N),
    .oGO_LED(oGO_LED), .oSTATE(oSTATE), .oTIME(oTIME), .oDONE_MASK(oDONE_MASK),
    .oFOUL_MASK(oFOUL_MASK), .oWINNER(oWINNER), .oWIN_VALID(oWIN_VALID),
    .oROUND_DONE(oROUND_DONE), .oBEST_TIME(oBEST_TIME)
  );

  always #10 CLK_50 = ~CLK_50;

  typedef struct packed {
    logic [15:0] t1, t0;
    logic [1:0]  done, foul;
    logic [2:0]  win;
    logic        wv;
    logic [15:0] best;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0, n_err = 0, n_pulse = 0, n_push = 0;
  logic [15:0] best_m = 16'hFFFF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [15:0] t1, input logic [15:0] t0, input logic [1:0] done,
                          input logic [1:0] foul, input logic [2:0] win, input logic wv);
    exp_t e;
    e.t1 = t1; e.t0 = t0; e.done = done; e.foul = foul; e.win = win; e.wv = wv;
`ifdef BEST_TIME_EN
    if (wv) begin
      if (win == 3'd0 && t0 < best_m) best_m = t0;
      if (win == 3'd1 && t1 < best_m) best_m = t1;
    end
    e.best = best_m;
`else
    e.best = 16'hFFFF;
`endif
    sb_q.push_back(e);
    n_push++;
  endtask

  task automatic start_round();
    @(negedge CLK_50); iSTART = 1'b1;
    @(negedge CLK_50); iSTART = 1'b0;
  endtask

  task automatic wait_state(input logic [1:0] target, input int budget, output int cyc);
    cyc = 0;
    while (oSTATE !== target && cyc < budget) begin
      @(negedge CLK_50);
      cyc++;
    end
    if (oSTATE !== target) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_state: got state %0d after %0d cycles, expected %0d", oSTATE, cyc, target);
    end
  endtask

  always @(negedge CLK_50) begin
    exp_t e;
    if (RESET_N && oROUND_DONE) begin
      n_pulse++;
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL round_done: got unexpected pulse, expected none");
      end else begin
        e = sb_q.pop_front();
        check("state_result", oSTATE, 2'd3);
        check("go_led_result", oGO_LED, 1'b0);
        check("time0", oTIME[15:0], e.t0);
        check("time1", oTIME[31:16], e.t1);
        check("done_mask", oDONE_MASK, e.done);
        check("foul_mask", oFOUL_MASK, e.foul);
        check("win_valid", oWIN_VALID, e.wv);
        if (e.wv) check("winner", oWINNER, e.win);
        check("best_time", oBEST_TIME, e.best);
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got no completion, expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp + 1, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc;
    logic seen_timing;
    int  best_ticks[3] = '{60, 40, 70};

    #200;
    check("rst_state", oSTATE, 2'd0);
    check("rst_time", oTIME, 32'd0);
    check("rst_done", oDONE_MASK, 2'b00);
    check("rst_foul", oFOUL_MASK, 2'b00);
    check("rst_go", oGO_LED, 1'b0);
    check("rst_winvld", oWIN_VALID, 1'b0);
    check("rst_best", oBEST_TIME, 16'hFFFF);
    RESET_N = 1'b1;

    // Staggered presses at ticks 250 and 300.
    push_exp(16'd300, 16'd250, 2'b11, 2'b00, 3'd0, 1'b1);
    start_round();
    wait_state(2'd2, 2000, cyc);
    check("arm_delay_clks", cyc, 500);
    check("go_led_timing", oGO_LED, 1'b1);
    repeat (250 * 50 + 10) @(negedge CLK_50);
    iKEY_N[0] = 1'b0;
    repeat (50 * 50) @(negedge CLK_50);
    iKEY_N[1] = 1'b0;
    wait_state(2'd3, 5000, cyc);
    iKEY_N = 2'b11;

    // Same-clock presses at tick 120.
    push_exp(16'd120, 16'd120, 2'b11, 2'b00, 3'd0, 1'b1);
    start_round();
    wait_state(2'd2, 2000, cyc);
    repeat (120 * 50 + 10) @(negedge CLK_50);
    iKEY_N = 2'b00;
    wait_state(2'd3, 5000, cyc);
    iKEY_N = 2'b11;

    // Player 1 false start, player 0 at tick 50.
    push_exp(16'hFFFF, 16'd50, 2'b01, 2'b10, 3'd0, 1'b1);
    start_round();
    repeat (100) @(negedge CLK_50);
    iKEY_N[1] = 1'b0;
    wait_state(2'd2, 2000, cyc);
    repeat (50 * 50 + 10) @(negedge CLK_50);
    iKEY_N[0] = 1'b0;
    wait_state(2'd3, 5000, cyc);
    iKEY_N = 2'b11;

    // Both players foul: straight to RESULT.
    push_exp(16'hFFFF, 16'hFFFF, 2'b00, 2'b11, 3'd0, 1'b0);
    start_round();
    repeat (100) @(negedge CLK_50);
    iKEY_N = 2'b00;
    seen_timing = 1'b0;
    cyc = 0;
    while (oSTATE !== 2'd3 && cyc < 2000) begin
      @(negedge CLK_50);
      if (oSTATE === 2'd2) seen_timing = 1'b1;
      cyc++;
    end
    check("all_foul_result", oSTATE, 2'd3);
    check("all_foul_no_timing", seen_timing, 1'b0);
    iKEY_N = 2'b11;

    // No presses: timeout after 400 ticks.
    push_exp(16'hFFFF, 16'hFFFF, 2'b00, 2'b00, 3'd0, 1'b0);
    start_round();
    wait_state(2'd2, 2000, cyc);
    wait_state(2'd3, 30000, cyc);
    check("timeout_clks", cyc, 20000);

    // Asynchronous reset in the middle of TIMING.
    start_round();
    wait_state(2'd2, 2000, cyc);
    repeat (100) @(negedge CLK_50);
    check("go_before_abort", oGO_LED, 1'b1);
    #3;
    RESET_N = 1'b0;
    best_m  = 16'hFFFF;
    #2;
    check("abort_state", oSTATE, 2'd0);
    check("abort_go", oGO_LED, 1'b0);
    check("abort_time", oTIME, 32'd0);
    check("abort_best", oBEST_TIME, 16'hFFFF);
    repeat (10) @(negedge CLK_50);
    RESET_N = 1'b1;

    // Best-time sequence after reset.
    for (int r = 0; r < 3; r++) begin
      push_exp(16'(best_ticks[r]), 16'(best_ticks[r]), 2'b11, 2'b00, 3'd0, 1'b1);
      start_round();
      wait_state(2'd2, 2000, cyc);
      repeat (best_ticks[r] * 50 + 10) @(negedge CLK_50);
      iKEY_N = 2'b00;
      wait_state(2'd3, 5000, cyc);
      iKEY_N = 2'b11;
    end

    repeat (5) @(negedge CLK_50);
    check("scoreboard_drained", sb_q.size(), 0);
    check("round_done_pulses", n_pulse, n_push);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
